// File: rtl/wb_arb_pkg.sv
// Shared types, constants and helpers for the Wishbone master arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: the search starts one past the
// base pointer and wraps modulo N; the first set request wins.
module rr_priority_picker
  import wb_arb_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  localparam int unsigned NU = N;

  // Scan candidates ptr+1 .. ptr+N and take the first requester.
  always_comb begin
    int unsigned   c;
    logic [IW-1:0] ci;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    ci      = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      c  = (32'(ptr_i) + k) % NU;
      ci = IW'(c);
      if (!valid_o && req_i[ci]) begin
        valid_o   = 1'b1;
        idx_o     = ci;
        gnt_o[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// N-channel to single Wishbone master arbiter. One single-beat transaction
// at a time; the bus is held until ack or timeout, then a one-cycle response
// is returned to the owning channel.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          NUM_MASTERS    = 3,
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          ARB_MODE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_rsp_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              cyc_o,
  output logic                              stb_o,
  output logic                              we_o,
  output logic [ADDR_WIDTH-1:0]             addr_o,
  output logic [DATA_WIDTH-1:0]             data_o,
  input  logic                              ack_i,
  input  logic [DATA_WIDTH-1:0]             data_i
);

  localparam int          IW     = idx_width(NUM_MASTERS);
  localparam int          CNT_W  = idx_width(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LIM = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  arb_state_t             state_q;
  logic [IW-1:0]          ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] rsp_q;
  logic [NUM_MASTERS-1:0] err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   cyc_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;

  logic [IW-1:0]          pick_ptr;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  // Fixed priority reuses the rotating picker with the base parked at the
  // top index, so the scan always begins at channel 0.
  assign pick_ptr = (ARB_MODE == ARB_RR) ? ptr_q : IW'(NUM_MASTERS - 1);

  rr_priority_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req_i   (m_req_i),
    .ptr_i   (pick_ptr),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Arbitration FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      rsp_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            addr_q  <= m_addr_i[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= m_wdata_i[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
            we_q    <= m_we_i[pick_idx];
            grant_q <= pick_gnt;
            ptr_q   <= pick_idx;
            cyc_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          // ack has priority over a timeout expiring in the same cycle.
          if (ack_i) begin
            rdata_q <= data_i;
            rsp_q   <= grant_q;
            err_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= RESP;
          end else if (TO_EN && cnt_q == CNT_W'(TO_LIM)) begin
            rdata_q <= '0;
            rsp_q   <= grant_q;
            err_q   <= grant_q;
            cyc_q   <= 1'b0;
            state_q <= RESP;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          rsp_q   <= '0;
          err_q   <= '0;
          grant_q <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_rsp_o   = rsp_q;
  assign m_err_o   = err_q;
  assign m_rdata_o = rdata_q;
  assign grant_o   = grant_q;
  assign cyc_o     = cyc_q;
  assign stb_o     = cyc_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign data_o    = wdata_q;

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- N-master to single-Wishbone-master arbiter.
- It generalises the core's hard-wired split between the cache multiplexer and the uncached peripheral path into a parametrised block.
- Each channel (I-cache refill, D-cache refill/writeback, uncached data, later DMA) issues one registered single-beat transaction at a time.
- The arbiter selects one channel by fixed or round-robin priority and holds the bus until ack or timeout. It then returns a one-cycle response, with an error flag on timeout.

Parameters:
- NUM_MASTERS, 3, number of request channels (2..8).
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 1024, max cycles waiting for ack_i; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- m_req_i  in  NUM_MASTERS  per-channel request, held high until that channel's m_rsp_o
- m_we_i  in  NUM_MASTERS  per-channel write enable
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed per-channel address
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  packed per-channel write data
- m_rsp_o  out  NUM_MASTERS  one-cycle response pulse to the granted channel
- m_err_o  out  NUM_MASTERS  error qualifier, valid with m_rsp_o
- m_rdata_o  out  DATA_WIDTH  shared read data, valid with any m_rsp_o bit
- grant_o  out  NUM_MASTERS  one-hot current owner; 0 when idle
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe (equals cyc_o)
- we_o  out  1  Wishbone write enable
- addr_o  out  ADDR_WIDTH  Wishbone address
- data_o  out  DATA_WIDTH  Wishbone write data
- ack_i  in  1  Wishbone acknowledge
- data_i  in  DATA_WIDTH  Wishbone read data

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer = NUM_MASTERS-1, so channel 0 wins first; timeout counter 0. Reset mid-transaction drops cyc_o at that edge; no response is issued.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If any m_req_i bit is set, pick winner g.
  - Register addr/we/wdata of g into addr_o/we_o/data_o; set cyc_o = stb_o = 1 and grant_o = 1<<g; go to BUS.
  - The bus therefore asserts 1 cycle after the request is sampled.
- BUS:
  - Outputs stay frozen.
  - The counter increments each cycle without ack.
  - On ack_i: rdata <= data_i, m_rsp_o[g] <= 1, m_err_o[g] <= 0, cyc/stb/we <= 0, go to RESP.
- Timeout: when TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES-1 without ack_i:
  - Drop cyc/stb.
  - Set m_rsp_o[g] = 1, m_err_o[g] = 1, rdata <= 0; go to RESP.
  - If ack_i arrives in the same cycle as the timeout, ack wins: normal response, no error.
- RESP:
  - m_rsp_o/m_err_o are high for exactly this cycle; grant_o still shows g.
  - m_req_i is ignored here, so the finishing master sees rsp and may drop or reissue req.
  - Next state is IDLE; clear grant_o, rsp, err and counter.
- Latency: request sampled → response = ack wait + 2 cycles, minimum 3 when the slave acks in the first BUS cycle.
- Back-to-back: at least one IDLE cycle between transactions; cyc_o deasserts for ≥ 2 cycles (RESP + IDLE).
- Fixed mode: lowest set index wins.
- Round-robin mode:
  - Search starts at pointer+1 with modulo-NUM_MASTERS wrap.
  - The pointer updates to g on grant.
  - A channel that is the only requester wins every time.
- Channel inputs are sampled only in IDLE; changes during BUS have no effect.
- Latched address width and data width follow the parameters; no truncation or sign extension.
- ack_i outside BUS is ignored.

Decomposition:
- Package wb_arb_pkg:
  - state enum arb_state_t {IDLE, BUS, RESP}
  - constants ARB_FIXED = 0, ARB_RR = 1
  - function clog2-safe index width
- Sub-module rr_priority_picker: combinational.
  - Inputs: req vector and base pointer.
  - Outputs: one-hot grant, binary index and valid.
  - Fixed mode instantiates it with pointer tied to NUM_MASTERS-1.

Test Plan:
- Single read: ch1 req, addr 0x8000_0010; slave acks 2 cycles after cyc → addr_o 0x8000_0010, we_o 0, rsp[1] pulses 1 cycle with rdata = slave value 0xDEAD_BEEF, err 0.
- Fixed priority: ARB_MODE=0, ch0 and ch2 req together, ack immediate → ch0 served first, then ch2; rsp order 0, 2.
- Round-robin fairness: ARB_MODE=1, all 3 channels req continuously, reissuing after rsp → grant sequence 0, 1, 2, 0, 1, 2.
- Write: ch2 we=1, wdata 0x1234_5678 → data_o = 0x1234_5678, we_o 1 for the whole cycle, rsp[2] after ack.
- Timeout: TIMEOUT_CYCLES=8, slave never acks → cyc drops after 8 BUS cycles, rsp[g] and err[g] = 1, rdata 0; with ack on cycle 8 instead → err 0.
- Reset mid-BUS: assert rst_n=0 while cyc_o=1 → next edge cyc_o=0, grant_o=0, no rsp; first grant after release goes to ch0.
